// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 serial controller.
package ltc2308_pkg;
  localparam int CFG_W   = 6;
  localparam int DATA_W  = 12;
  localparam int NBITS   = 12;
  localparam int TIMER_W = 8;

  // Config word bit positions, MSB is shifted out first
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [2:0] {
    IDLE, CONV_HI, CONV_WAIT, SHIFT_LO, SHIFT_HI, HOLD, GAP
  } state_e;

  // SDI level for a given readout bit index: cfg bits ride on indices 11..6, zeros after
  function automatic logic sdi_bit(input logic [CFG_W-1:0] cfg, input logic [3:0] idx);
    logic [3:0] k;
    k = idx - 4'(NBITS - CFG_W);
    if (idx >= 4'(NBITS - CFG_W) && idx <= 4'(NBITS - 1)) return cfg[k[2:0]];
    return 1'b0;
  endfunction
endpackage

// File: rtl/ltc2308_sck_gen.sv
// SCK phase generator: SCK_HALF clk cycles per phase, 12 bits, index counts 11..0.
module ltc2308_sck_gen import ltc2308_pkg::*; #(
  parameter int SCK_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       sck,
  output logic       rise_en,
  output logic       fall_en,
  output logic       done,
  output logic [3:0] bit_idx
);
  localparam int PH_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic            active;
  logic [PH_W-1:0] ph;
  logic            ph_end;

  // Strobes describe what the coming clock edge does to SCK
  assign ph_end  = active && (ph == PH_W'(SCK_HALF - 1));
  assign rise_en = ph_end && !sck;
  assign fall_en = ph_end && sck;
  assign done    = fall_en && (bit_idx == 4'd0);

  // Phase counter, SCK toggle and bit index (decremented on each falling edge)
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      sck     <= 1'b0;
      ph      <= '0;
      bit_idx <= '0;
    end else if (start) begin
      active  <= 1'b1;
      sck     <= 1'b0;
      ph      <= '0;
      bit_idx <= 4'(NBITS - 1);
    end else if (active) begin
      if (ph_end) begin
        ph  <= '0;
        sck <= ~sck;
        if (sck) begin
          if (bit_idx == 4'd0) active <= 1'b0;
          else                 bit_idx <= bit_idx - 4'd1;
        end
      end else begin
        ph <= ph + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ltc2308_ctrl.sv
// LTC2308 controller: CONVST pulse, conversion wait, 12-bit SCK readout with config on SDI.
module ltc2308_ctrl import ltc2308_pkg::*; #(
  parameter int CONVST_HI = 2,
  parameter int CONV_CYC  = 82,
  parameter int SCK_HALF  = 1,
  parameter int CYC_CYC   = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CFG_W-1:0]  cmd_cfg,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [CFG_W-1:0]  res_cfg,
  output logic              adc_convst,
  output logic              adc_sck,
  output logic              adc_sdi,
  input  logic              adc_sdo
);
  state_e             state;
  logic [TIMER_W-1:0] timer;
  logic [CFG_W-1:0]   cur_cfg, prev_cfg;
  logic [NBITS-1:0]   data_sr;
  logic               hold_cnt;
  logic               sck_start, rise_en, fall_en, done, accept;
  logic [3:0]         bit_idx;

  assign cmd_ready = !rst && (state == IDLE) && (timer >= TIMER_W'(CYC_CYC));
  assign accept    = cmd_valid && cmd_ready;
  assign sck_start = (state == CONV_WAIT) && (timer == TIMER_W'(CONV_CYC - 1));

  ltc2308_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck (
    .clk     (clk),
    .rst     (rst),
    .start   (sck_start),
    .sck     (adc_sck),
    .rise_en (rise_en),
    .fall_en (fall_en),
    .done    (done),
    .bit_idx (bit_idx)
  );

  // Cycle timer: zero at the CONVST rise, saturates so an idle controller is always ready
  always_ff @(posedge clk) begin
    if (rst)                   timer <= '1;
    else if (accept)           timer <= '0;
    else if (timer != '1)      timer <= timer + 1'b1;
  end

  // Main sequencer; all pin and result outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      adc_convst <= 1'b0;
      adc_sdi    <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_cfg    <= '0;
      cur_cfg    <= '0;
      prev_cfg   <= '0;
      data_sr    <= '0;
      hold_cnt   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cur_cfg    <= cmd_cfg;
          adc_convst <= 1'b1;
          state      <= CONV_HI;
        end
        CONV_HI: if (timer == TIMER_W'(CONVST_HI - 1)) begin
          adc_convst <= 1'b0;
          state      <= CONV_WAIT;
        end
        CONV_WAIT: if (sck_start) begin
          adc_sdi <= sdi_bit(cur_cfg, 4'(NBITS - 1));
          state   <= SHIFT_LO;
        end
        SHIFT_LO: if (rise_en) begin
          data_sr <= {data_sr[NBITS-2:0], adc_sdo};
          state   <= SHIFT_HI;
        end
        SHIFT_HI: begin
          if (done) begin
            adc_sdi  <= 1'b0;
            hold_cnt <= 1'b0;
            state    <= HOLD;
          end else if (fall_en) begin
            adc_sdi <= sdi_bit(cur_cfg, bit_idx - 4'd1);
            state   <= SHIFT_LO;
          end
        end
        // First HOLD cycle is the last SCK-low phase; the second is the quiet tHCONVST cycle
        HOLD: begin
          if (hold_cnt) begin
            res_valid <= 1'b1;
            res_data  <= data_sr;
            res_cfg   <= prev_cfg;
            prev_cfg  <= cur_cfg;
            state     <= GAP;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        GAP: if (timer >= TIMER_W'(CYC_CYC)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Directed bench: two controllers (default timing and a slow SCK sweep) with an ADC pin model.
module tb_ltc2308_ctrl;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [5:0] cmd_cfg   [2];
  logic       res_valid [2];
  logic [11:0] res_data [2];
  logic [5:0] res_cfg   [2];
  logic       convst [2];
  logic       sck    [2];
  logic       sdi    [2];
  logic       sdo    [2] = '{1'b0, 1'b0};
  logic [11:0] word  [2] = '{12'h0, 12'h0};

  int n_chk = 0;
  int n_err = 0;

  // model state
  int          cyc = 0;
  logic        p_cv  [2] = '{1'b0, 1'b0};
  logic        p_sck [2] = '{1'b0, 1'b0};
  logic [3:0]  ptr   [2] = '{4'd0, 4'd0};
  logic        ptr_v [2] = '{1'b0, 1'b0};
  int          nrise [2] = '{0, 0};
  int          rise_cyc [2] = '{0, 0};
  logic        has_rise [2] = '{1'b0, 1'b0};
  logic [11:0] sdi_sh [2] = '{12'h0, 12'h0};
  int          res_cnt [2] = '{0, 0};
  int          res_lat [2] = '{0, 0};
  logic [11:0] res_d [2] = '{12'h0, 12'h0};
  logic [5:0]  res_c [2] = '{6'h0, 6'h0};

  genvar g;
  generate for (g = 0; g < 2; g++) begin : gi
    ltc2308_ctrl #(
      .CONVST_HI (2),
      .CONV_CYC  (g == 0 ? 82 : 90),
      .SCK_HALF  (g == 0 ? 1 : 2),
      .CYC_CYC   (100)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_cfg    (cmd_cfg[g]),
      .res_valid  (res_valid[g]),
      .res_data   (res_data[g]),
      .res_cfg    (res_cfg[g]),
      .adc_convst (convst[g]),
      .adc_sck    (sck[g]),
      .adc_sdi    (sdi[g]),
      .adc_sdo    (sdo[g])
    );
  end endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ADC pin model, sampled on the falling clk edge: drives SDO, captures SDI, checks timing
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      p_cv[i]  <= convst[i];
      p_sck[i] <= sck[i];
      if (convst[i] && !p_cv[i]) begin
        if (has_rise[i]) chk("tcyc", ((cyc - rise_cyc[i]) >= 100) ? 1 : 0, 1);
        rise_cyc[i] <= cyc;
        has_rise[i] <= 1'b1;
        nrise[i]    <= 0;
      end
      if (!convst[i] && p_cv[i]) begin
        chk("twhconv", cyc - rise_cyc[i], 2);
        sdo[i]   <= word[i][11];
        ptr[i]   <= 4'd10;
        ptr_v[i] <= 1'b1;
      end
      if (sck[i] && !p_sck[i]) begin
        if (nrise[i] == 0) chk("tconv", cyc - rise_cyc[i], (i == 0) ? 83 : 92);
        nrise[i]  <= nrise[i] + 1;
        sdi_sh[i] <= {sdi_sh[i][10:0], sdi[i]};
      end
      if (!sck[i] && p_sck[i] && ptr_v[i]) begin
        sdo[i] <= word[i][ptr[i]];
        if (ptr[i] == 4'd0) ptr_v[i] <= 1'b0;
        else                ptr[i]   <= ptr[i] - 4'd1;
      end
      if (res_valid[i]) begin
        res_cnt[i] <= res_cnt[i] + 1;
        res_lat[i] <= cyc - rise_cyc[i];
        res_d[i]   <= res_data[i];
        res_c[i]   <= res_cfg[i];
      end
    end
  end

  task automatic send(input int k, input logic [5:0] cfg);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid[k] = 1'b1;
    cmd_cfg[k]   = cfg;
    while (!cmd_ready[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", 32'(cmd_ready[k]), 1);
    @(negedge clk);
    cmd_valid[k] = 1'b0;
  endtask

  task automatic wait_res(input int k, input int base);
    int n;
    n = 0;
    while (res_cnt[k] <= base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("res_seen", (res_cnt[k] > base) ? 1 : 0, 1);
  endtask

  initial begin
    int b, acc, n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_cfg[i]   = 6'h0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(cmd_ready[0]), 0);
    chk("rst_ready1", 32'(cmd_ready[1]), 0);
    chk("rst_convst", 32'(convst[0]), 0);
    chk("rst_sck",    32'(sck[0]), 0);
    chk("rst_sdi",    32'(sdi[0]), 0);
    chk("rst_rv",     32'(res_valid[0]), 0);
    chk("rst_rd",     32'(res_data[0]), 0);
    chk("rst_rc",     32'(res_cfg[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst0", 32'(cmd_ready[0]), 1);
    chk("ready_after_rst1", 32'(cmd_ready[1]), 1);

    // single command, latency and SDI pattern
    word[0] = 12'hA5C;
    b = res_cnt[0];
    send(0, 6'b100010);
    wait_res(0, b);
    chk("c1_lat",  32'(res_lat[0]), 108);
    chk("c1_data", 32'(res_d[0]), 32'h0A5C);
    chk("c1_cfg",  32'(res_c[0]), 0);
    chk("c1_sdi",  32'(sdi_sh[0][11:6]), 32'b100010);
    chk("c1_sdi0", 32'(sdi_sh[0][5:0]), 0);

    // back-to-back, config pipelining
    word[0] = 12'h3C7;
    b = res_cnt[0];
    send(0, 6'h22);
    send(0, 6'h3F);
    wait_res(0, b + 1);
    chk("c2_data", 32'(res_d[0]), 32'h03C7);
    chk("c2_cfg",  32'(res_c[0]), 32'h22);
    chk("c2_sdi",  32'(sdi_sh[0][11:6]), 32'h3F);

    // cmd_valid held for five commands
    word[0] = 12'h0F0;
    b = res_cnt[0];
    acc = 0;
    n = 0;
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_cfg[0]   = 6'h05;
    while (acc < 5 && n < 3000) begin
      if (cmd_ready[0]) acc++;
      @(negedge clk);
      n++;
    end
    cmd_valid[0] = 1'b0;
    chk("c3_acc", 32'(acc), 5);
    repeat (400) @(negedge clk);
    chk("c3_npulse", 32'(res_cnt[0] - b), 5);
    chk("c3_data",   32'(res_d[0]), 32'h0F0);
    chk("c3_cfg",    32'(res_c[0]), 32'h05);

    // SDO all zeros, then all ones
    word[0] = 12'h000;
    b = res_cnt[0];
    send(0, 6'h11);
    wait_res(0, b);
    chk("c4_zero", 32'(res_d[0]), 0);
    word[0] = 12'hFFF;
    b = res_cnt[0];
    send(0, 6'h2C);
    wait_res(0, b);
    chk("c4_ones", 32'(res_d[0]), 32'hFFF);

    // reset in the middle of readout, bit index 5
    word[0] = 12'h777;
    b = res_cnt[0];
    send(0, 6'h3F);
    n = 0;
    while (nrise[0] != 0 && n < 200) begin @(negedge clk); n++; end
    while (nrise[0] < 6 && n < 400) begin @(negedge clk); n++; end
    chk("c5_reach", (nrise[0] >= 6) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("c5_convst", 32'(convst[0]), 0);
    chk("c5_sck",    32'(sck[0]), 0);
    chk("c5_sdi",    32'(sdi[0]), 0);
    chk("c5_rv",     32'(res_valid[0]), 0);
    chk("c5_rd",     32'(res_data[0]), 0);
    chk("c5_rc",     32'(res_cfg[0]), 0);
    chk("c5_rdy_in", 32'(cmd_ready[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("c5_rdy_out", 32'(cmd_ready[0]), 1);
    repeat (150) @(negedge clk);
    chk("c5_no_res", 32'(res_cnt[0] - b), 0);
    word[0] = 12'h5A3;
    send(0, 6'h11);
    wait_res(0, b);
    chk("c5_data", 32'(res_d[0]), 32'h5A3);
    chk("c5_cfg",  32'(res_c[0]), 0);
    chk("c5_lat",  32'(res_lat[0]), 108);

    // slow SCK instance: SCK_HALF=2, CONV_CYC=90
    word[1] = 12'hC3A;
    b = res_cnt[1];
    send(1, 6'h2A);
    wait_res(1, b);
    chk("c6_lat",  32'(res_lat[1]), 140);
    chk("c6_data", 32'(res_d[1]), 32'hC3A);
    chk("c6_cfg",  32'(res_c[1]), 0);
    chk("c6_sdi",  32'(sdi_sh[1][11:6]), 32'h2A);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
